// File: rtl/display_scan_controller_pkg.sv
// Shared constants and state encoding for the multi-digit status display scanner.
package display_scan_controller_pkg;

  localparam int unsigned STATUS_W   = 2;
  localparam int unsigned MAX_DIGITS = 32;

  // All digits off on a common-anode display (active-low enables); sliced to N_DIGITS by users.
  localparam logic [MAX_DIGITS-1:0] DIGITS_OFF = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// Loadable down-counter that paces the SHOW and BLANK phases; done when the count reaches zero.
module scan_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_count;

  // Saturates at zero; the FSM reloads it on every phase entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_done_c = (r_count == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Scans N_DIGITS status codes onto one decoder and an active-low digit bus, with a blanking gap
// between digits and a per-frame snapshot of the statuses.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned CLK_DIV      = 3,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [STATUS_W*N_DIGITS-1:0] std_in,
  output logic [N_DIGITS-1:0]          digit_sel,
  output logic [STATUS_W-1:0]          cur_status,
  output logic                         blank,
  output logic                         frame_done
);

  localparam int unsigned TMAX  = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W = $clog2(TMAX + 1);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0]    SHOW_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]    BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] SEL_OFF    = DIGITS_OFF[N_DIGITS-1:0];
  localparam logic [N_DIGITS-1:0] SEL_ONE    = N_DIGITS'(1);

  state_t                       r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [STATUS_W*N_DIGITS-1:0] r_shadow;

  logic                w_tmr_clr;
  logic                w_tmr_load;
  logic [CNT_W-1:0]    w_tmr_val;
  logic                w_tmr_done;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [N_DIGITS-1:0] w_sel_nxt;
  logic [STATUS_W-1:0] w_status_nxt;
  logic [STATUS_W-1:0] w_status_first;

  assign w_idx_nxt      = r_idx + IDX_W'(1);
  assign w_sel_nxt      = ~(SEL_ONE << w_idx_nxt);
  assign w_status_nxt   = r_shadow[w_idx_nxt*STATUS_W +: STATUS_W];
  assign w_status_first = std_in[STATUS_W-1:0];

  // Timer control mirrors the FSM transitions taken on the same edge.
  always_comb begin
    w_tmr_clr  = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = SHOW_LOAD;
        end else begin
          w_tmr_clr = 1'b1;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          w_tmr_clr = 1'b1;
        end else if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = BLANK_LOAD;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          w_tmr_clr = 1'b1;
        end else if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = SHOW_LOAD;
        end
      end
      default: w_tmr_clr = 1'b1;
    endcase
  end

  scan_timer #(
    .CNT_W(CNT_W)
  ) u_scan_timer (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_clr     (w_tmr_clr),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .o_done_c  (w_tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_shadow   <= '0;
      digit_sel  <= SEL_OFF;
      cur_status <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state    <= ST_SHOW;
            r_idx      <= '0;
            r_shadow   <= std_in;
            digit_sel  <= ~SEL_ONE;
            cur_status <= w_status_first;
            blank      <= 1'b0;
          end
        end
        ST_SHOW: begin
          if (!enable) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            digit_sel  <= SEL_OFF;
            cur_status <= '0;
            blank      <= 1'b1;
          end else if (w_tmr_done) begin
            r_state   <= ST_BLANK;
            digit_sel <= SEL_OFF;
            blank     <= 1'b1;
          end
        end
        ST_BLANK: begin
          if (!enable) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            digit_sel  <= SEL_OFF;
            cur_status <= '0;
            blank      <= 1'b1;
          end else if (w_tmr_done) begin
            r_state <= ST_SHOW;
            blank   <= 1'b0;
            // Frame wrap: take a fresh snapshot and restart at digit 0.
            if (r_idx == LAST_IDX) begin
              r_idx      <= '0;
              r_shadow   <= std_in;
              digit_sel  <= ~SEL_ONE;
              cur_status <= w_status_first;
              frame_done <= 1'b1;
            end else begin
              r_idx      <= w_idx_nxt;
              digit_sel  <= w_sel_nxt;
              cur_status <= w_status_nxt;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_idx      <= '0;
          digit_sel  <= SEL_OFF;
          cur_status <= '0;
          blank      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: expected {digit_sel, cur_status, blank, frame_done} per cycle, two configurations.
module tb_display_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en1, en2;
  logic [7:0] std1;
  logic [3:0] std2;
  logic [3:0] sel1;
  logic [1:0] st1;
  logic       blank1, fd1;
  logic [1:0] sel2;
  logic [1:0] st2;
  logic       blank2, fd2;

  int n_tests = 0;
  int n_fail  = 0;
  logic onehot_on = 1'b0;

  logic [7:0] q1[$];
  logic [5:0] q2[$];

  display_scan_controller #(.N_DIGITS(4), .CLK_DIV(3), .BLANK_CYCLES(1)) u_dut4 (
    .clk(clk), .reset(reset), .enable(en1), .std_in(std1),
    .digit_sel(sel1), .cur_status(st1), .blank(blank1), .frame_done(fd1)
  );

  display_scan_controller #(.N_DIGITS(2), .CLK_DIV(1), .BLANK_CYCLES(1)) u_dut2 (
    .clk(clk), .reset(reset), .enable(en2), .std_in(std2),
    .digit_sel(sel2), .cur_status(st2), .blank(blank2), .frame_done(fd2)
  );

  // At most one digit may be lit in any cycle.
  always @(negedge clk) begin
    if (onehot_on) begin
      n_tests++;
      assert ($countones(~sel1) <= 1 && $countones(~sel2) <= 1) else begin
        n_fail++;
        $error("FAIL onehot: sel4=%b sel2=%b required at most one low bit", sel1, sel2);
      end
    end
  end

  // One frame of the 4-digit config: 3 SHOW cycles then 1 BLANK per digit.
  task automatic push4(input logic [7:0] snap, input logic wrap, input int n_ent);
    int k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        logic [3:0] s;
        s = 4'b1111;
        if (c < 3) s[d] = 1'b0;
        if (k < n_ent) q1.push_back({s, snap[2*d +: 2], (c == 3), (wrap && d == 0 && c == 0)});
        k++;
      end
    end
  endtask

  task automatic push2(input logic [3:0] snap, input logic wrap);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        logic [1:0] s;
        s = 2'b11;
        if (c == 0) s[d] = 1'b0;
        q2.push_back({s, snap[2*d +: 2], (c == 1), (wrap && d == 0 && c == 0)});
      end
    end
  endtask

  task automatic push_idle(input int n);
    repeat (n) begin
      q1.push_back({4'b1111, 2'b00, 1'b1, 1'b0});
      q2.push_back({2'b11, 2'b00, 1'b1, 1'b0});
    end
  endtask

  task automatic check4(input string tag);
    logic [7:0] obs, exp;
    obs = {sel1, st1, blank1, fd1};
    n_tests++;
    if (q1.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %b required entry missing from scoreboard", tag, obs);
    end else begin
      exp = q1.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: sel/st/blank/fd observed %b required %b at %0t", tag, obs, exp, $time);
      end
    end
  endtask

  task automatic check2(input string tag);
    logic [5:0] obs, exp;
    obs = {sel2, st2, blank2, fd2};
    n_tests++;
    if (q2.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %b required entry missing from scoreboard", tag, obs);
    end else begin
      exp = q2.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: sel/st/blank/fd observed %b required %b at %0t", tag, obs, exp, $time);
      end
    end
  endtask

  task automatic step4(input int n, input string tag);
    repeat (n) begin
      @(posedge clk); #1;
      check4(tag);
    end
  endtask

  task automatic step2(input int n, input string tag);
    repeat (n) begin
      @(posedge clk); #1;
      check2(tag);
    end
  endtask

  initial begin
    reset = 1'b0;
    en1   = 1'b0;
    en2   = 1'b0;
    std1  = 8'h00;
    std2  = 4'h0;

    // Reset asserted between edges takes effect before the next edge.
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    onehot_on = 1'b1;
    push_idle(1);
    #1 check4("reset_async4"); check2("reset_async2");
    push_idle(1);
    step4(1, "reset_hold4"); check2("reset_hold2");
    @(negedge clk) reset = 1'b0;
    push_idle(2);
    repeat (2) begin
      @(posedge clk); #1; check4("idle4"); check2("idle2");
    end

    // Continuous scan; std_in change mid-frame takes effect only at the next wrap.
    std1 = 8'b11_10_01_00;
    en1  = 1'b1;
    push4(8'hE4, 1'b0, 16);
    push4(8'hE4, 1'b1, 16);
    push4(8'hE4, 1'b1, 16);
    push4(8'hFF, 1'b1, 16);
    push4(8'hFF, 1'b1, 9);
    step4(37, "scan_e4");
    std1 = 8'hFF;
    step4(36, "scan_ff");

    // Drop enable during SHOW of digit 2.
    en1 = 1'b0;
    q1.push_back({4'b1111, 2'b00, 1'b1, 1'b0});
    q1.push_back({4'b1111, 2'b00, 1'b1, 1'b0});
    q1.push_back({4'b1111, 2'b00, 1'b1, 1'b0});
    step4(3, "disable");

    // Re-enable restarts at digit 0 with a fresh snapshot.
    std1 = 8'h1B;
    en1  = 1'b1;
    push4(8'h1B, 1'b0, 16);
    push4(8'h9C, 1'b1, 4);
    step4(16, "reenable");
    std1 = 8'h9C;
    step4(4, "wrap_9c");

    // Reset in the middle of BLANK, released with enable still high.
    #1 reset = 1'b1;
    push_idle(1);
    #1 check4("reset_blank4"); check2("reset_blank2");
    std1 = 8'h36;
    @(negedge clk) reset = 1'b0;
    push4(8'h36, 1'b0, 16);
    push4(8'h36, 1'b1, 1);
    step4(17, "after_reset");

    // Minimal configuration: 2 digits, 1 SHOW + 1 BLANK cycle.
    en1  = 1'b0;
    std2 = 4'b11_01;
    en2  = 1'b1;
    push2(4'b1101, 1'b0);
    push2(4'b1101, 1'b1);
    push2(4'b1101, 1'b1);
    step2(12, "small_cfg");

    onehot_on = 1'b0;
    n_tests++;
    assert (q1.size() == 0 && q2.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d/%0d entries left required 0/0", q1.size(), q2.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
